// File: rtl/rbm_label_voter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rbm_label_voter                                              |
// | Description : Relaunches the label-layer RBM SAMPLE_NUM times, tallies each |
// |               binary output into per-class vote counters and reports the   |
// |               class with the most votes. Optional macro                    |
// |               RBM_VOTE_EARLY_EXIT_EN ends a decision once a class holds a  |
// |               strict majority of SAMPLE_NUM.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rbm_label_voter #(
    parameter int OUTPUT_DIM      = 10,
    parameter int SAMPLE_NUM      = 16,
    parameter int CNT_BITLENGTH   = 8,
    parameter int LABEL_BITLENGTH = 4,
    parameter int ID              = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       layer_finish,
    input  logic [OUTPUT_DIM-1:0]      layer_data,
    output logic                       layer_reset,
    output logic                       busy,
    output logic [CNT_BITLENGTH-1:0]   sample_count,
    output logic [LABEL_BITLENGTH-1:0] label,
    output logic                       label_valid
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RELAUNCH = 3'd1,
        S_WAIT     = 3'd2,
        S_ACCUM    = 3'd3,
        S_SCAN     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [CNT_BITLENGTH-1:0]   c_sample_num = CNT_BITLENGTH'(SAMPLE_NUM);
    localparam logic [LABEL_BITLENGTH-1:0] c_last_class = LABEL_BITLENGTH'(OUTPUT_DIM - 1);

    if (OUTPUT_DIM > (1 << LABEL_BITLENGTH) || SAMPLE_NUM < 1 ||
        SAMPLE_NUM >= (1 << CNT_BITLENGTH) || ID < 0) begin : g_bad_config
        $error("rbm_label_voter: inconsistent parameters");
    end

    state_t                     r_state;
    logic [CNT_BITLENGTH-1:0]   r_counters     [OUTPUT_DIM];
    logic [CNT_BITLENGTH-1:0]   w_new_counters [OUTPUT_DIM];
    logic [OUTPUT_DIM-1:0]      r_data;
    logic                       r_seen_low;
    logic [LABEL_BITLENGTH-1:0] r_scan_idx;
    logic [LABEL_BITLENGTH-1:0] r_best_idx;
    logic [CNT_BITLENGTH-1:0]   r_best_cnt;
    logic [CNT_BITLENGTH-1:0]   r_sample_count;
    logic [CNT_BITLENGTH-1:0]   w_next_sample_count;
    logic                       w_scan_better;
    logic                       r_layer_reset;
    logic                       r_busy;
    logic [LABEL_BITLENGTH-1:0] r_label;
    logic                       r_label_valid;

    always_comb begin
        for (int c = 0; c < OUTPUT_DIM; c++) begin
            w_new_counters[c] = r_counters[c] + CNT_BITLENGTH'(r_data[c]);
        end
        w_next_sample_count = r_sample_count + CNT_BITLENGTH'(1);
        w_scan_better       = r_counters[r_scan_idx] > r_best_cnt;
    end

`ifdef RBM_VOTE_EARLY_EXIT_EN
    localparam logic [CNT_BITLENGTH-1:0] c_majority = CNT_BITLENGTH'(SAMPLE_NUM / 2);

    logic                       w_exit_hit;
    logic [LABEL_BITLENGTH-1:0] w_exit_idx;

    // Descending scan so the lowest qualifying class is the one left standing
    always_comb begin
        w_exit_hit = 1'b0;
        w_exit_idx = '0;
        for (int c = OUTPUT_DIM - 1; c >= 0; c--) begin
            if (w_new_counters[c] > c_majority) begin
                w_exit_hit = 1'b1;
                w_exit_idx = LABEL_BITLENGTH'(c);
            end
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_data         <= '0;
            r_seen_low     <= 1'b0;
            r_scan_idx     <= '0;
            r_best_idx     <= '0;
            r_best_cnt     <= '0;
            r_sample_count <= '0;
            r_layer_reset  <= 1'b0;
            r_busy         <= 1'b0;
            r_label        <= '0;
            r_label_valid  <= 1'b0;
            for (int c = 0; c < OUTPUT_DIM; c++) r_counters[c] <= '0;
        end else begin
            r_layer_reset <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int c = 0; c < OUTPUT_DIM; c++) r_counters[c] <= '0;
                        r_sample_count <= '0;
                        r_busy         <= 1'b1;
                        r_layer_reset  <= 1'b1;
                        r_state        <= S_RELAUNCH;
                    end
                end
                S_RELAUNCH: begin
                    r_seen_low <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A finish left high by the previous run must drop before it counts
                    if (!layer_finish) begin
                        r_seen_low <= 1'b1;
                    end else if (r_seen_low) begin
                        r_data  <= layer_data;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    for (int c = 0; c < OUTPUT_DIM; c++) r_counters[c] <= w_new_counters[c];
                    r_sample_count <= w_next_sample_count;
`ifdef RBM_VOTE_EARLY_EXIT_EN
                    if (w_exit_hit) begin
                        r_label       <= w_exit_idx;
                        r_label_valid <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_DONE;
                    end else
`endif
                    if (w_next_sample_count == c_sample_num) begin
                        r_scan_idx <= '0;
                        r_best_idx <= '0;
                        r_best_cnt <= '0;
                        r_state    <= S_SCAN;
                    end else begin
                        r_layer_reset <= 1'b1;
                        r_state       <= S_RELAUNCH;
                    end
                end
                S_SCAN: begin
                    if (w_scan_better) begin
                        r_best_idx <= r_scan_idx;
                        r_best_cnt <= r_counters[r_scan_idx];
                    end
                    if (r_scan_idx == c_last_class) begin
                        r_label       <= w_scan_better ? r_scan_idx : r_best_idx;
                        r_label_valid <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= S_DONE;
                    end else begin
                        r_scan_idx <= r_scan_idx + LABEL_BITLENGTH'(1);
                    end
                end
                S_DONE: begin
                    if (start) begin
                        for (int c = 0; c < OUTPUT_DIM; c++) r_counters[c] <= '0;
                        r_sample_count <= '0;
                        r_label_valid  <= 1'b0;
                        r_busy         <= 1'b1;
                        r_layer_reset  <= 1'b1;
                        r_state        <= S_RELAUNCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign layer_reset  = r_layer_reset;
    assign busy         = r_busy;
    assign sample_count = r_sample_count;
    assign label        = r_label;
    assign label_valid  = r_label_valid;

endmodule
`default_nettype wire

// File: tb/tb_rbm_label_voter.sv
`default_nettype none
// Bench for rbm_label_voter: scripted upstream layer, expected decisions queued at start and
// checked by a monitor on each label_valid rise.
module tb_rbm_label_voter;

    localparam int SN = 4;
`ifdef RBM_VOTE_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       layer_finish = 1'b1;
    logic [9:0] layer_data = '0;
    logic       layer_reset;
    logic       busy;
    logic [7:0] sample_count;
    logic [3:0] label;
    logic       label_valid;

    rbm_label_voter #(
        .OUTPUT_DIM(10), .SAMPLE_NUM(SN), .CNT_BITLENGTH(8), .LABEL_BITLENGTH(4), .ID(0)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .layer_finish(layer_finish),
        .layer_data(layer_data), .layer_reset(layer_reset), .busy(busy),
        .sample_count(sample_count), .label(label), .label_valid(label_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] lbl;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: counts relaunch pulses, scores each new decision against the queue
    initial begin
        logic prev_valid = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (layer_reset === 1'b1) n_pulses++;
            if (label_valid === 1'b1 && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_decision", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_label"}, label, e.lbl);
                    chk({e.name, "_count"}, sample_count, e.cnt);
                end
            end
            prev_valid = (label_valid === 1'b1);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // One upstream run: wait for relaunch, keep finish high for 'hold' cycles, drop, then raise with data
    task automatic do_run(input logic [9:0] d, input int hold, input int k);
        int guard = 0;
        while (layer_reset !== 1'b1 && guard < 60) begin
            @(negedge clock);
            guard++;
        end
        if (layer_reset !== 1'b1) begin
            chk("relaunch_seen", layer_reset, 1);
            return;
        end
        repeat (hold) @(negedge clock);
        if (hold > 0) chk("no_capture_while_high", sample_count, k);
        layer_finish = 1'b0;
        repeat (2) @(negedge clock);
        layer_data   = d;
        layer_finish = 1'b1;
        @(negedge clock);
    endtask

    task automatic wait_done(input string name);
        int guard = 0;
        while (label_valid !== 1'b1 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        chk({name, "_done"}, label_valid, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         p0;
        logic [9:0] t4_data [4];
        t4_data[0] = 10'h200; t4_data[1] = 10'h201; t4_data[2] = 10'h200; t4_data[3] = 10'h001;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_count", sample_count, 0);
        chk("rst_label", label, 0);
        chk("rst_valid", label_valid, 0);
        chk("rst_layer_reset", layer_reset, 0);

        // T2: class 3 every run
        sb_q.push_back('{4'd3, EE ? 8'd3 : 8'd4, "t2"});
        p0 = n_pulses;
        pulse_start();
        chk("t2_busy", busy, 1);
        for (int i = 0; i < (EE ? 3 : 4); i++) do_run(10'b00_0000_1000, 0, i);
        wait_done("t2");
        chk("t2_pulses", n_pulses - p0, EE ? 3 : 4);
        chk("t2_busy_low", busy, 0);

        // T3 tie 2/2 -> lowest index; T5 start from DONE then start during SCAN
        sb_q.push_back('{4'd2, 8'd4, "t3"});
        pulse_start();
        chk("t5_valid_cleared", label_valid, 0);
        chk("t5_busy_restart", busy, 1);
        for (int i = 0; i < 4; i++) do_run(i[0] ? 10'b00_0010_0000 : 10'b00_0000_0100, i, i);
        repeat (2) @(negedge clock);
        pulse_start();
        wait_done("t3");
        p0 = n_pulses;
        repeat (12) @(negedge clock);
        chk("t5_no_restart_pulse", n_pulses - p0, 0);
        chk("t5_valid_held", label_valid, 1);

        // T4: finish held high across relaunch on every run, multi-bit vote in run 1
        sb_q.push_back('{4'd9, EE ? 8'd3 : 8'd4, "t4"});
        pulse_start();
        for (int i = 0; i < (EE ? 3 : 4); i++) do_run(t4_data[i], 3, i);
        wait_done("t4");

        // T1: abort by reset while waiting on the third run
        pulse_start();
        for (int i = 0; i < 2; i++) do_run(10'b00_0000_0010, 0, i);
        while (layer_reset !== 1'b1) @(negedge clock);
        repeat (2) @(negedge clock);
        p0 = n_pulses;
        reset = 1'b1;
        @(negedge clock);
        chk("t1_busy", busy, 0);
        chk("t1_count", sample_count, 0);
        chk("t1_valid", label_valid, 0);
        chk("t1_label", label, 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("t1_no_pulse", n_pulses - p0, 0);

        // All-zero votes from IDLE -> label 0
        sb_q.push_back('{4'd0, 8'd4, "zero"});
        pulse_start();
        for (int i = 0; i < 4; i++) do_run(10'b0, 1, i);
        wait_done("zero");

        repeat (3) @(negedge clock);
        chk("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
